// File: rtl/utils_pkg.sv
// Shared AXI4 slave channel bundles, response codes and the boot/reset controller register map.
package utils_pkg;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;

  localparam logic [1:0]  AXI_OKAY       = 2'b00;
  localparam logic [1:0]  AXI_SLVERR     = 2'b10;
  localparam logic [15:0] BOOT_ADDR_BASE = 16'h0000;
  localparam logic [15:0] CTRL_OFF       = 16'h0100;
  localparam logic [15:0] PULSE_OFF      = 16'h0104;

  typedef enum logic [1:0] {WR_IDLE, WR_HOLD, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_RESP} rd_state_e;
  typedef enum logic [1:0] {REG_BOOT, REG_CTRL, REG_PULSE, REG_ERR} reg_kind_e;

  // word is the 32-bit word offset (byte address bits [15:2])
  function automatic reg_kind_e decode_reg(logic [13:0] word, int n_cores);
    if (int'(word - BOOT_ADDR_BASE[15:2]) < n_cores) return REG_BOOT;
    if (word == CTRL_OFF[15:2])  return REG_CTRL;
    if (word == PULSE_OFF[15:2]) return REG_PULSE;
    return REG_ERR;
  endfunction

  function automatic logic [31:0] strb_mask(logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/rst_pulse_gen.sv
// Per-core reset generator: holds rst_n_o low for PULSE_CYCLES cycles after start_i, else follows release_i.
// release_i and start_i are next-state values so the output reacts the cycle after the register commit.
module rst_pulse_gen #(
  parameter int   PULSE_CYCLES    = 16,
  parameter logic RST_RELEASE_DEF = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic release_i,
  output logic busy_o,
  output logic rst_n_o
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_n_q, rst_n_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)            cnt_d = CW'(PULSE_CYCLES);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
    rst_n_d = release_i && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rst_n_q <= RST_RELEASE_DEF;
    end else begin
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rst_n_o = rst_n_q;

endmodule

// File: rtl/boot_rst_ctrl.sv
// AXI4-lite-style slave holding per-core boot addresses, reset release bits and timed reset pulses.
// Single-beat only: AW/W captured independently, one write outstanding, one read outstanding.
module boot_rst_ctrl
  import utils_pkg::*;
#(
  parameter int          N_CORES         = 2,
  parameter logic [31:0] DEF_BOOT_ADDR   = 32'h8000_0000,
  parameter logic        RST_RELEASE_DEF = 1'b0,
  parameter int          PULSE_CYCLES    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  s_axi_mosi_t               axi_mosi,
  output s_axi_miso_t               axi_miso,
  output logic [N_CORES-1:0][31:0]  rst_addr_o,
  output logic [N_CORES-1:0]        core_rst_n_o
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [13:0] awword_q, awword_d;
  logic [3:0]  awid_q, awid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  bid_q, bid_d, rid_q, rid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [N_CORES-1:0][31:0] boot_q, boot_d;
  logic [N_CORES-1:0]       ctrl_q, ctrl_d, pulse_start, busy;

  logic        aw_rdy, w_rdy, aw_fire, w_fire, commit;
  logic [13:0] wr_word;
  logic [31:0] wr_data, wr_mask;
  logic [3:0]  wr_strb, wr_id;
  reg_kind_e   wr_kind, rd_kind;

  logic unused_axi;
  assign unused_axi = ^{axi_mosi.awaddr[31:16], axi_mosi.awaddr[1:0], axi_mosi.awlen,
                        axi_mosi.awsize, axi_mosi.awburst, axi_mosi.wlast,
                        axi_mosi.araddr[31:16], axi_mosi.araddr[1:0], axi_mosi.arlen,
                        axi_mosi.arsize, axi_mosi.arburst};

  // A beat that handshakes this cycle merges with a held partner so the commit needs no extra cycle.
  always_comb begin
    aw_rdy  = !aw_held_q && (wr_state_q != WR_RESP);
    w_rdy   = !w_held_q && (wr_state_q != WR_RESP);
    aw_fire = axi_mosi.awvalid && aw_rdy;
    w_fire  = axi_mosi.wvalid && w_rdy;
    wr_word = aw_held_q ? awword_q : axi_mosi.awaddr[15:2];
    wr_id   = aw_held_q ? awid_q   : axi_mosi.awid;
    wr_data = w_held_q  ? wdata_q  : axi_mosi.wdata;
    wr_strb = w_held_q  ? wstrb_q  : axi_mosi.wstrb;
    wr_kind = decode_reg(wr_word, N_CORES);
    commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awword_d   = awword_q;
    awid_d     = awid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE, WR_HOLD: begin
        if (commit) begin
          wr_state_d = WR_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bid_d      = wr_id;
          bresp_d    = (wr_kind == REG_ERR) ? AXI_SLVERR : AXI_OKAY;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awword_d  = axi_mosi.awaddr[15:2];
            awid_d    = axi_mosi.awid;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = axi_mosi.wdata;
            wstrb_d  = axi_mosi.wstrb;
          end
          wr_state_d = (aw_held_d || w_held_d) ? WR_HOLD : WR_IDLE;
        end
      end
      WR_RESP: if (axi_mosi.bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    boot_d      = boot_q;
    ctrl_d      = ctrl_q;
    pulse_start = '0;
    wr_mask     = strb_mask(wr_strb);
    if (commit) begin
      case (wr_kind)
        REG_BOOT: begin
          for (int i = 0; i < N_CORES; i++)
            if (wr_word == 14'(i)) boot_d[i] = (boot_q[i] & ~wr_mask) | (wr_data & wr_mask);
        end
        REG_CTRL:  ctrl_d = (ctrl_q & ~wr_mask[N_CORES-1:0]) | (wr_data[N_CORES-1:0] & wr_mask[N_CORES-1:0]);
        REG_PULSE: pulse_start = wr_data[N_CORES-1:0] & wr_mask[N_CORES-1:0];
        default: ;
      endcase
    end
  end

  // Read data is sampled from the current registers, so a same-cycle commit is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_kind    = decode_reg(axi_mosi.araddr[15:2], N_CORES);
    case (rd_state_q)
      RD_IDLE: begin
        if (axi_mosi.arvalid) begin
          rd_state_d = RD_RESP;
          rid_d      = axi_mosi.arid;
          rdata_d    = '0;
          rresp_d    = AXI_OKAY;
          case (rd_kind)
            REG_BOOT: begin
              for (int i = 0; i < N_CORES; i++)
                if (axi_mosi.araddr[15:2] == 14'(i)) rdata_d = boot_q[i];
            end
            REG_CTRL:  rdata_d = 32'(ctrl_q);
            REG_PULSE: rdata_d = 32'(busy);
            default:   rresp_d = AXI_SLVERR;
          endcase
        end
      end
      RD_RESP: if (axi_mosi.rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awword_q   <= '0;
      awid_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bid_q      <= '0;
      bresp_q    <= AXI_OKAY;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= AXI_OKAY;
      boot_q     <= {N_CORES{DEF_BOOT_ADDR}};
      ctrl_q     <= {N_CORES{RST_RELEASE_DEF}};
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awword_q   <= awword_d;
      awid_q     <= awid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      boot_q     <= boot_d;
      ctrl_q     <= ctrl_d;
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    rst_pulse_gen #(
      .PULSE_CYCLES    (PULSE_CYCLES),
      .RST_RELEASE_DEF (RST_RELEASE_DEF)
    ) u_pulse (
      .clk       (clk),
      .rst       (rst),
      .start_i   (pulse_start[g]),
      .release_i (ctrl_d[g]),
      .busy_o    (busy[g]),
      .rst_n_o   (core_rst_n_o[g])
    );
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = aw_rdy;
    axi_miso.wready  = w_rdy;
    axi_miso.bid     = bid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.bvalid  = (wr_state_q == WR_RESP);
    axi_miso.arready = (rd_state_q == RD_IDLE);
    axi_miso.rid     = rid_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = (rd_state_q == RD_RESP);
    axi_miso.rvalid  = (rd_state_q == RD_RESP);
  end

  assign rst_addr_o = boot_q;

endmodule
